// File: rtl/inputcond_pkg.sv
//------------------------------------------------------------------------------
// Module   : inputcond_pkg
// Brief    : Shared debounce state encoding and glitch-counter constants.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package inputcond_pkg;

    typedef enum logic [0:0] {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } state_t;

    localparam int                      GLITCH_CNT_W   = 8;
    localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/inputcond_channel.sv
//------------------------------------------------------------------------------
// Module   : inputcond_channel
// Brief    : One synchroniser + debounce FSM + edge-pulse slice.
//            Optional glitch counter under INPUTCOND_GLITCH_CNT_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module inputcond_channel
    import inputcond_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   COUNTER_WIDTH = 3,
    parameter int   WAIT_TIME     = 3,
    parameter logic RESET_VALUE   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef INPUTCOND_GLITCH_CNT_EN
    input  logic                    i_glitch_clr,
    output logic [GLITCH_CNT_W-1:0] o_glitch_cnt,
`endif
    input  logic                    i_noisy,
    output logic                    o_conditioned,
    output logic                    o_posedge_p,
    output logic                    o_negedge_p
);

    localparam logic [COUNTER_WIDTH-1:0] c_WAIT_CNT = COUNTER_WIDTH'(WAIT_TIME);

    logic [SYNC_STAGES-1:0]   r_sync;
    logic                     r_cond;
    logic                     r_pos;
    logic                     r_neg;
    logic [COUNTER_WIDTH-1:0] r_cnt;
    state_t                   r_state;
    logic                     w_s;
    logic                     w_abort;

    assign w_s     = r_sync[SYNC_STAGES-1];
    assign w_abort = (r_state == ST_COUNT) && (w_s == r_cond);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= {SYNC_STAGES{RESET_VALUE}};
            r_cond  <= RESET_VALUE;
            r_pos   <= 1'b0;
            r_neg   <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_STABLE;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_noisy};
            r_pos  <= 1'b0;
            r_neg  <= 1'b0;
            unique case (r_state)
                ST_STABLE: begin
                    r_cnt <= '0;
                    if (w_s != r_cond) begin
                        // With no dwell the first differing sample commits directly.
                        if (WAIT_TIME == 0) begin
                            r_cond <= w_s;
                            r_pos  <= w_s;
                            r_neg  <= ~w_s;
                        end else begin
                            r_state <= ST_COUNT;
                            r_cnt   <= COUNTER_WIDTH'(1);
                        end
                    end
                end
                ST_COUNT: begin
                    if (w_abort) begin
                        r_state <= ST_STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_WAIT_CNT) begin
                        r_cond  <= w_s;
                        r_pos   <= w_s;
                        r_neg   <= ~w_s;
                        r_state <= ST_STABLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + COUNTER_WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= ST_STABLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_conditioned = r_cond;
    assign o_posedge_p   = r_pos;
    assign o_negedge_p   = r_neg;

`ifdef INPUTCOND_GLITCH_CNT_EN
    logic [GLITCH_CNT_W-1:0] r_glitch_cnt;

    // Clear has priority over a coincident abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_glitch_cnt <= '0;
        end else if (i_glitch_clr) begin
            r_glitch_cnt <= '0;
        end else if (w_abort && (r_glitch_cnt != GLITCH_CNT_MAX)) begin
            r_glitch_cnt <= r_glitch_cnt + GLITCH_CNT_W'(1);
        end
    end

    assign o_glitch_cnt = r_glitch_cnt;
`endif

endmodule

`default_nettype wire

// File: rtl/multi_input_conditioner.sv
//------------------------------------------------------------------------------
// Module   : multi_input_conditioner
// Brief    : NCHAN independent debounced inputs with edge pulses and any_edge.
//            Glitch counters enabled by defining INPUTCOND_GLITCH_CNT_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multi_input_conditioner
    import inputcond_pkg::*;
#(
    parameter int   NCHAN         = 4,
    parameter int   SYNC_STAGES   = 2,
    parameter int   COUNTER_WIDTH = 3,
    parameter int   WAIT_TIME     = 3,
    parameter logic RESET_VALUE   = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NCHAN-1:0]              noisy,
    output logic [NCHAN-1:0]              conditioned,
    output logic [NCHAN-1:0]              posedge_p,
    output logic [NCHAN-1:0]              negedge_p,
`ifdef INPUTCOND_GLITCH_CNT_EN
    input  logic                          glitch_clr,
    output logic [NCHAN*GLITCH_CNT_W-1:0] glitch_cnt,
`endif
    output logic                          any_edge
);

    logic r_any_edge;

    if (((2 ** COUNTER_WIDTH) - 1) < WAIT_TIME) begin : g_width_check
        $error("COUNTER_WIDTH too small to hold WAIT_TIME");
    end

    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
        inputcond_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .WAIT_TIME     (WAIT_TIME),
            .RESET_VALUE   (RESET_VALUE)
        ) u_channel (
            .clk           (clk),
            .rst_n         (rst_n),
`ifdef INPUTCOND_GLITCH_CNT_EN
            .i_glitch_clr  (glitch_clr),
            .o_glitch_cnt  (glitch_cnt[gi*GLITCH_CNT_W +: GLITCH_CNT_W]),
`endif
            .i_noisy       (noisy[gi]),
            .o_conditioned (conditioned[gi]),
            .o_posedge_p   (posedge_p[gi]),
            .o_negedge_p   (negedge_p[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_any_edge <= 1'b0;
        end else begin
            r_any_edge <= |(posedge_p | negedge_p);
        end
    end

    assign any_edge = r_any_edge;

endmodule

`default_nettype wire

// File: tb/tb_multi_input_conditioner.sv
//------------------------------------------------------------------------------
// Module   : tb_multi_input_conditioner
// Brief    : Scoreboard bench for multi_input_conditioner (default parameters).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_multi_input_conditioner;

    logic        clk;
    logic        rst_n;
    logic [3:0]  noisy;
    logic [3:0]  conditioned;
    logic [3:0]  posedge_p;
    logic [3:0]  negedge_p;
    logic        any_edge;
`ifdef INPUTCOND_GLITCH_CNT_EN
    logic        glitch_clr;
    logic [31:0] glitch_cnt;
`endif

    multi_input_conditioner dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .noisy       (noisy),
        .conditioned (conditioned),
        .posedge_p   (posedge_p),
        .negedge_p   (negedge_p),
`ifdef INPUTCOND_GLITCH_CNT_EN
        .glitch_clr  (glitch_clr),
        .glitch_cnt  (glitch_cnt),
`endif
        .any_edge    (any_edge)
    );

    typedef struct {
        int         cyc;
        logic [3:0] pos;
        logic [3:0] neg;
        logic [3:0] cond;
    } ev_t;

    ev_t  sb[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   errors   = 0;
    bit   mon_en   = 0;
    logic prev_hit = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulses are popped from the scoreboard; any_edge must trail them by one edge.
    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_any;
            ev_t  e;
            exp_any = rst_n ? prev_hit : 1'b0;
            checks++;
            if (any_edge !== exp_any) begin
                errors++;
                $display("FAIL any_edge cyc=%0d got=%b exp=%b", cyc, any_edge, exp_any);
            end
            if ((posedge_p | negedge_p) !== 4'b0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse cyc=%0d pos=%b neg=%b exp=none", cyc, posedge_p, negedge_p);
                end else begin
                    e = sb.pop_front();
                    if (cyc !== e.cyc || posedge_p !== e.pos || negedge_p !== e.neg || conditioned !== e.cond) begin
                        errors++;
                        $display("FAIL pulse got cyc=%0d pos=%b neg=%b cond=%b exp cyc=%0d pos=%b neg=%b cond=%b",
                                 cyc, posedge_p, negedge_p, conditioned, e.cyc, e.pos, e.neg, e.cond);
                    end
                end
            end
            prev_hit = rst_n && ((posedge_p | negedge_p) != 4'b0);
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic expect_drained(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s pending=%0d exp=0 (next exp cyc=%0d)", name, sb.size(), sb[0].cyc);
            sb.delete();
        end
    endtask

    task automatic push_ev(input int at, input logic [3:0] p, input logic [3:0] n, input logic [3:0] c);
        ev_t e;
        e.cyc = at; e.pos = p; e.neg = n; e.cond = c;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        noisy = 4'h0;
        tick(2);
        mon_en = 1;
        for (int i = 0; i < 5; i++) begin
            noisy = 4'($urandom_range(0, 15));
            tick();
            checks++;
            if ({conditioned, posedge_p, negedge_p, any_edge} !== 13'b0) begin
                errors++;
                $display("FAIL reset_hold cond=%b pos=%b neg=%b any=%b exp=all0",
                         conditioned, posedge_p, negedge_p, any_edge);
            end
        end
        noisy = 4'h0;
        tick();
        rst_n = 1'b1;
        tick(8);
        checks++;
        if (conditioned !== 4'h0) begin
            errors++;
            $display("FAIL reset_release cond=%b exp=0000", conditioned);
        end
    endtask

    task automatic test_clean_rise();
        noisy[0] = 1'b1;
        push_ev(cyc + 1 + 5, 4'b0001, 4'b0000, 4'b0001);
        tick(12);
        expect_drained("clean_rise");
    endtask

    task automatic test_glitch();
        noisy[1] = 1'b1;
        tick(2);
        noisy[1] = 1'b0;
        tick(10);
        expect_drained("glitch");
        checks++;
        if (conditioned !== 4'b0001) begin
            errors++;
            $display("FAIL glitch_cond cond=%b exp=0001", conditioned);
        end
`ifdef INPUTCOND_GLITCH_CNT_EN
        checks++;
        if (glitch_cnt[15:8] !== 8'd1) begin
            errors++;
            $display("FAIL glitch_cnt1 got=%0d exp=1", glitch_cnt[15:8]);
        end
`endif
    endtask

    task automatic test_simultaneous();
        noisy = 4'b1000;
        push_ev(cyc + 1 + 5, 4'b1000, 4'b0001, 4'b1000);
        tick(12);
        noisy = 4'b0001;
        push_ev(cyc + 1 + 5, 4'b0001, 4'b1000, 4'b0001);
        tick(12);
        expect_drained("simultaneous");
    endtask

    task automatic test_back_to_back();
        int n;
        noisy[2] = 1'b1;
        n = cyc + 1;
        push_ev(n + 5, 4'b0100, 4'b0000, 4'b0101);
        push_ev(n + 9, 4'b0000, 4'b0100, 4'b0001);
        tick(4);
        noisy[2] = 1'b0;
        tick(12);
        expect_drained("back_to_back");
    endtask

    task automatic test_reset_mid_count();
        noisy[2] = 1'b1;
        tick(4);
        rst_n = 1'b0;
        noisy = 4'h0;
        #1;
        checks++;
        if ({conditioned, posedge_p, negedge_p} !== 12'b0) begin
            errors++;
            $display("FAIL mid_reset cond=%b pos=%b neg=%b exp=all0", conditioned, posedge_p, negedge_p);
        end
        tick(2);
        rst_n = 1'b1;
        tick(12);
        expect_drained("mid_reset_nopulse");
        checks++;
        if (conditioned !== 4'h0) begin
            errors++;
            $display("FAIL mid_reset_cond cond=%b exp=0000", conditioned);
        end
    endtask

`ifdef INPUTCOND_GLITCH_CNT_EN
    task automatic test_glitch_saturate();
        for (int i = 0; i < 300; i++) begin
            noisy[0] = 1'b1;
            tick();
            noisy[0] = 1'b0;
            tick(2);
        end
        tick(3);
        checks++;
        if (glitch_cnt[7:0] !== 8'd255) begin
            errors++;
            $display("FAIL glitch_sat got=%0d exp=255", glitch_cnt[7:0]);
        end
        noisy[0] = 1'b1;
        tick();
        noisy[0] = 1'b0;
        tick(2);
        glitch_clr = 1'b1;
        tick();
        glitch_clr = 1'b0;
        tick(3);
        checks++;
        if (glitch_cnt[7:0] !== 8'd0) begin
            errors++;
            $display("FAIL glitch_clr_wins got=%0d exp=0", glitch_cnt[7:0]);
        end
        expect_drained("glitch_sat_nopulse");
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        noisy = 4'h0;
`ifdef INPUTCOND_GLITCH_CNT_EN
        glitch_clr = 1'b0;
`endif
        test_reset();
        test_clean_rise();
        test_glitch();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_count();
`ifdef INPUTCOND_GLITCH_CNT_EN
        test_glitch_saturate();
`endif
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
